// File: rtl/button_seq_pkg.sv
// Shared definitions for the button sequencer: FSM states, symbol geometry
// and the fixed symbol-to-button encoding.
package button_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_SYMBOLS = 4;
    localparam int SYMBOL_W    = 2;
    localparam int BTN_W       = 3;

    // Fixed mapping from a 2-bit symbol to the button pattern the checker expects.
    function automatic logic [BTN_W-1:0] encode(input logic [SYMBOL_W-1:0] sym);
        logic [BTN_W-1:0] pattern;
        case (sym)
            2'b00:   pattern = 3'b001;
            2'b01:   pattern = 3'b010;
            2'b10:   pattern = 3'b100;
            default: pattern = 3'b011;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/button_sequencer_latency_timer.sv
// Verdict latency timer: counts cycles from the final button release to the
// checker's first success/fail, saturating at all-ones.
// Only present when BUTTON_SEQUENCER_LATENCY_EN is defined.
`ifdef BUTTON_SEQUENCER_LATENCY_EN
module latency_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_arm,      // final release edge: clear and start counting
    input  logic        i_abort,    // new guess accepted: drop an open measurement
    input  logic        i_verdict,  // success || fail from the checker
    output logic [31:0] o_latency,
    output logic        o_valid
);

    logic        r_armed;
    logic [31:0] r_count;
    logic [31:0] r_latency;
    logic        r_valid;

    // Arm/count/stop; arming wins over a verdict seen on the release edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_count   <= '0;
            r_latency <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_arm) begin
                r_armed <= 1'b1;
                r_count <= '0;
            end else if (r_armed) begin
                if (i_abort) begin
                    r_armed <= 1'b0;
                end else if (i_verdict) begin
                    r_latency <= r_count;
                    r_valid   <= 1'b1;
                    r_armed   <= 1'b0;
                end else if (r_count != 32'hFFFF_FFFF) begin
                    r_count <= r_count + 32'd1;
                end
            end
        end
    end

    assign o_latency = r_latency;
    assign o_valid   = r_valid;

endmodule
`endif

// File: rtl/button_sequencer.sv
// Button sequencer: sends an 8-bit guess as four timed presses on a 3-bit
// button bus, each press followed by an all-released gap.
// Optional macro BUTTON_SEQUENCER_LATENCY_EN adds the verdict latency timer.
module button_sequencer
    import button_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned PRESS_US      = 2_000,
    parameter int unsigned GAP_US        = 2_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  guess,
    output logic        ready,
    output logic [2:0]  btn,
    output logic        done,
    input  logic        success,
    input  logic        fail,
    output logic [31:0] latency,
    output logic        latency_valid
);

    localparam int unsigned PRESS_CYC = CLK_FREQUENCY / 1_000_000 * PRESS_US;
    localparam int unsigned GAP_CYC   = CLK_FREQUENCY / 1_000_000 * GAP_US;
    localparam int unsigned MAX_CYC   = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int          CNT_W     = $clog2(MAX_CYC + 1);
    localparam int          IDX_W     = $clog2(NUM_SYMBOLS);
    localparam int          SHIFT_W   = NUM_SYMBOLS * SYMBOL_W;

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SYMBOLS - 1);

    // A zero-length press or gap would make the counters wrap; refuse to build.
    generate
        if (PRESS_CYC == 0 || GAP_CYC == 0) begin : g_bad_timing
            $fatal(1, "button_sequencer: PRESS_CYC and GAP_CYC must be non-zero");
        end
    endgenerate

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [SHIFT_W-1:0]   r_shift, w_shift_next;
    logic [BTN_W-1:0]     r_btn, w_btn_next;
    logic                 r_done, w_done_next;
    logic                 w_accept;   // guess accepted this cycle
    logic                 w_arm;      // btn falls after the last press this cycle

    // State and datapath registers; reset drops the buttons immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_btn   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_btn   <= w_btn_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and next-output logic for the press/gap sequence.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_btn_next   = r_btn;
        w_done_next  = 1'b0;
        w_accept     = 1'b0;
        w_arm        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // First symbol comes straight from the input so it is on
                    // the bus one cycle after acceptance.
                    w_accept     = 1'b1;
                    w_shift_next = guess;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                    w_btn_next   = encode(guess[SHIFT_W-1 -: SYMBOL_W]);
                    w_state_next = PRESS;
                end
            end
            PRESS: begin
                if (r_cnt == PRESS_LAST) begin
                    w_cnt_next   = '0;
                    w_btn_next   = '0;
                    w_state_next = GAP;
                    w_arm        = (r_idx == IDX_LAST);
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next = '0;
                    if (r_idx != IDX_LAST) begin
                        w_idx_next   = r_idx + 1'b1;
                        w_shift_next = r_shift << SYMBOL_W;
                        w_btn_next   = encode(r_shift[SHIFT_W-SYMBOL_W-1 -: SYMBOL_W]);
                        w_state_next = PRESS;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = DONE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ready = (r_state == IDLE);
    assign btn   = r_btn;
    assign done  = r_done;

`ifdef BUTTON_SEQUENCER_LATENCY_EN
    latency_timer u_latency_timer (
        .clk       (clk),
        .rst       (rst),
        .i_arm     (w_arm),
        .i_abort   (w_accept),
        .i_verdict (success | fail),
        .o_latency (latency),
        .o_valid   (latency_valid)
    );
`else
    logic w_unused_verdict;
    assign w_unused_verdict = success ^ fail ^ w_arm ^ w_accept;
    assign latency          = '0;
    assign latency_valid    = 1'b0;
`endif

endmodule
